// File: rtl/counter_load_ctrl_pkg.sv
// Shared definitions for the counter load controller: FSM encoding and datapath width.
package counter_load_ctrl_pkg;

  localparam int unsigned CtrWidth = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/up_counter_load.sv
// Loadable up counter; load has priority over enable, wraps mod 2^WIDTH.
module up_counter_load #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= data;
    end else if (enable) begin
      out <= out + 1'b1;
    end
  end

endmodule

// File: rtl/counter_load_ctrl.sv
// Sequences one up_counter_load: accepts {start, limit, mode} commands and runs
// one-shot or auto-reload counts with pause/abort, emitting tick and done pulses.
module counter_load_ctrl
  import counter_load_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CtrWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_reload,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             done_abort
);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             done_abort_q, done_abort_d;

  logic             ctr_load;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_data;

  assign cmd_ready  = (state_q == StIdle) && !reset;
  assign busy       = (state_q == StRun);
  assign tick       = tick_q;
  assign done       = done_q;
  assign done_abort = done_abort_q;

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    limit_d      = limit_q;
    reload_d     = reload_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    done_abort_d = 1'b0;
    ctr_load     = 1'b0;
    ctr_enable   = 1'b0;
    ctr_data     = start_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          start_d  = cmd_start;
          limit_d  = cmd_limit;
          reload_d = cmd_reload;
          ctr_load = 1'b1;
          ctr_data = cmd_start;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Abort wins over both the terminal event and pause; counter holds.
        if (abort) begin
          state_d      = StIdle;
          done_d       = 1'b1;
          done_abort_d = 1'b1;
        end else if (!pause) begin
          if (count == limit_q) begin
            tick_d = 1'b1;
            if (reload_q) begin
              ctr_load = 1'b1;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            ctr_enable = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      start_q      <= '0;
      limit_q      <= '0;
      reload_q     <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      done_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      limit_q      <= limit_d;
      reload_q     <= reload_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      done_abort_q <= done_abort_d;
    end
  end

  up_counter_load #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .enable(ctr_enable),
    .data  (ctr_data),
    .out   (count)
  );

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Self-checking bench for counter_load_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_counter_load_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_start;
  logic [7:0] cmd_limit;
  logic       cmd_reload;
  logic       pause;
  logic       abort;
  logic       busy;
  logic [7:0] count;
  logic       tick;
  logic       done;
  logic       done_abort;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_run    = 1'b0;
  int m_count  = 0;
  bit m_tick   = 1'b0;
  bit m_done   = 1'b0;
  bit m_dab    = 1'b0;
  int m_start  = 0;
  int m_limit  = 0;
  bit m_reload = 1'b0;

  always #5 clk = ~clk;

  counter_load_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_limit (cmd_limit),
    .cmd_reload(cmd_reload),
    .pause     (pause),
    .abort     (abort),
    .busy      (busy),
    .count     (count),
    .tick      (tick),
    .done      (done),
    .done_abort(done_abort)
  );

  // Inputs change only at negedge, so they are stable here.
  always @(posedge clk) begin
    if (reset) begin
      m_run = 1'b0; m_count = 0; m_tick = 1'b0; m_done = 1'b0; m_dab = 1'b0;
      m_start = 0; m_limit = 0; m_reload = 1'b0;
    end else begin
      m_tick = 1'b0; m_done = 1'b0; m_dab = 1'b0;
      if (!m_run) begin
        if (cmd_valid) begin
          m_start = int'(cmd_start); m_limit = int'(cmd_limit); m_reload = cmd_reload;
          m_count = m_start;
          m_run   = 1'b1;
        end
      end else if (abort) begin
        m_run = 1'b0; m_done = 1'b1; m_dab = 1'b1;
      end else if (!pause) begin
        if ((m_limit - m_count + 256) % 256 == 0) begin
          m_tick = 1'b1;
          if (m_reload) m_count = m_start;
          else begin
            m_run = 1'b0; m_done = 1'b1;
          end
        end else begin
          m_count = (m_count + 1) % 256;
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cmp();
    check("count", int'(count), m_count);
    check("busy", int'(busy), int'(m_run));
    check("tick", int'(tick), int'(m_tick));
    check("done", int'(done), int'(m_done));
    if (m_done) check("done_abort", int'(done_abort), int'(m_dab));
    check("cmd_ready", int'(cmd_ready), int'(!m_run && !reset));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    model_cmp();
  endtask

  task automatic send(input int s, input int l, input bit r);
    cmd_valid  = 1'b1;
    cmd_start  = 8'(s);
    cmd_limit  = 8'(l);
    cmd_reload = r;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    bit hit = 1'b0;
    k = 0;
    while (!hit && k < 600) begin
      cyc();
      k++;
      if (done === 1'b1) hit = 1'b1;
    end
    if (!hit) check("done_timeout", 0, 1);
  endtask

  initial begin
    int k;
    int k2;
    int ticks;
    reset = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_limit = '0;
    cmd_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check("ready_after_reset", int'(cmd_ready), 1);

    // Reset held 2 cycles mid-run
    send(0, 200, 1'b0);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    cyc();
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 0);
    reset = 1'b0;
    cyc();
    check("rst_ready_after", int'(cmd_ready), 1);
    check("rst_no_done", int'(done), 0);

    // One-shot 5 -> 9
    send(5, 9, 1'b0);
    check("os_first", int'(count), 5);
    wait_done(k);
    check("os_latency", k, 5);
    check("os_abort_flag", int'(done_abort), 0);
    check("os_tick", int'(tick), 1);
    check("os_hold", int'(count), 9);
    cyc();
    check("os_hold_after", int'(count), 9);
    check("os_done_width", int'(done), 0);

    // Reload 250 -> 2 with wrap
    send(250, 2, 1'b1);
    ticks = 0;
    repeat (27) begin
      cyc();
      if (tick) begin
        ticks++;
        check("rl_tick_align", int'(count), 250);
      end
    end
    check("rl_tick_cnt", ticks, 3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("rl_abort_done", int'(done), 1);

    // One-shot 0 -> 3 paused 3 cycles at count 1
    send(0, 3, 1'b0);
    cyc();
    check("pause_at", int'(count), 1);
    pause = 1'b1;
    repeat (3) cyc();
    check("pause_hold", int'(count), 1);
    pause = 1'b0;
    wait_done(k2);
    check("pause_latency", 4 + k2, 7);

    // Abort mid-run at count 7
    send(5, 20, 1'b0);
    cyc();
    cyc();
    check("ab_at", int'(count), 7);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("ab_done", int'(done), 1);
    check("ab_flag", int'(done_abort), 1);
    check("ab_tick", int'(tick), 0);
    check("ab_count", int'(count), 7);

    // Abort on the terminal cycle
    send(0, 2, 1'b0);
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abl_flag", int'(done_abort), 1);
    check("abl_tick", int'(tick), 0);

    // Command held through a run; accepted only in the done cycle
    send(10, 14, 1'b0);
    cmd_valid = 1'b1; cmd_start = 8'd0; cmd_limit = 8'd0; cmd_reload = 1'b0;
    wait_done(k);
    check("b2b_latency", k, 5);
    check("b2b_ready", int'(cmd_ready), 1);
    cyc();
    cmd_valid = 1'b0;
    check("b2b_count", int'(count), 0);
    check("b2b_busy", int'(busy), 1);
    cyc();
    check("b2b_done", int'(done), 1);

    // Random phase
    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      cmd_valid  = $urandom_range(0, 1) == 1;
      cmd_start  = 8'($urandom);
      cmd_limit  = cmd_start + 8'($urandom_range(0, 10));
      cmd_reload = $urandom_range(0, 1) == 1;
      pause      = ($urandom_range(0, 4) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
